// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and scoreboard for the 32x32 register file: round-robin
// sharing of the single write port plus pending-destination hazard tracking.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic [4:0]      req0_addr,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [4:0]      req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            raw_hazard,
    output logic            rf_en,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd
);

    logic [31:0]     pend;
    logic [31:0]     pend_next;
    logic            last;
    logic            accept;
    logic            grant;
    logic [4:0]      sel_addr;
    logic [XLEN-1:0] sel_data;

    // Under contention the requester that did not win last time is granted.
    always_comb begin
        req0_ready = req0_valid && (!req1_valid || last);
        req1_ready = req1_valid && (!req0_valid || !last);
        accept     = req0_ready || req1_ready;
        grant      = req1_ready;
        sel_addr   = grant ? req1_addr : req0_addr;
        sel_data   = grant ? req1_data : req0_data;
    end

    always_comb begin
        pend_next = pend;
        if (rf_en) begin
            pend_next[rf_wa] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            pend_next[issue_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    assign issue_ready = ~pend[issue_rd];
    assign raw_hazard  = pend[rs1_addr] | pend[rs2_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            last  <= 1'b1;
            rf_en <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            pend  <= pend_next;
            rf_en <= accept && (sel_addr != '0);
            if (accept) begin
                last <= grant;
            end
            // Dropped x0 writes leave the write address/data untouched.
            if (accept && (sel_addr != '0)) begin
                rf_wa <= sel_addr;
                rf_wd <= sel_data;
            end
        end
    end

endmodule
